arbitro_gerenciador_ativos: RTL and testbench
=============================================

# arbitro_gerenciador_ativos

Shares the active-node manager (`gerenciador_ativos`) between `NUM_REQ` requesters that issue deactivate (`desativar`) and update (`atualizar`) commands for active nodes (NA).

- The block owns the manager's command port.
- It serialises one command at a time and only issues while the manager is idle.
- It arbitrates round-robin among requesters.
- With the configuration macro compiled in, deactivations win over updates, so NA slots are freed before new nodes are requested.

## Interface
- `NUM_REQ`, 4: number of requesters.
- `REQ_IDX_WIDTH`, 2: `$clog2(NUM_REQ)`.
- `ADDR_WIDTH`, 5: node address width.
- `DISTANCIA_WIDTH`, 5: distance width.
- `CUSTO_WIDTH`, 4: cost width.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_desativar_in` in `NUM_REQ`: per-requester deactivate request, level.
- `req_atualizar_in` in `NUM_REQ`: per-requester update request, level.
- `req_endereco_in` in `ADDR_WIDTH*NUM_REQ`: packed node address; slice i = `[ADDR_WIDTH*i +: ADDR_WIDTH]`.
- `req_anterior_in` in `ADDR_WIDTH*NUM_REQ`: packed predecessor address.
- `req_menor_vizinho_in` in `CUSTO_WIDTH*NUM_REQ`: packed smallest-neighbour cost.
- `req_distancia_in` in `DISTANCIA_WIDTH*NUM_REQ`: packed distance.
- `ga_ocupado_in` in 1: manager busy.
- `ga_buffers_cheios_in` in 1: manager has no free NA.
- `arb_grant_out` out `NUM_REQ`: one-hot, one-cycle acknowledge.
- `arb_indice_out` out `REQ_IDX_WIDTH`: index of the requester currently being served.
- `arb_desativar_out` out 1: one-cycle command pulse to the manager.
- `arb_atualizar_out` out 1: one-cycle command pulse to the manager.
- `arb_endereco_out` out `ADDR_WIDTH`: latched payload.
- `arb_anterior_out` out `ADDR_WIDTH`: latched payload.
- `arb_menor_vizinho_out` out `CUSTO_WIDTH`: latched payload.
- `arb_distancia_out` out `DISTANCIA_WIDTH`: latched payload.
- `arb_ocupado_o` out 1: state != ST_IDLE.

## Operation
- **Reset.** All outputs are 0. State is ST_IDLE. The round-robin pointer is `NUM_REQ-1`, so requester 0 is searched first.
- **Request handshake.**
  - A requester holds its request and payload stable until its `arb_grant_out` bit pulses, then drops the granted request on the next cycle.
  - If a requester asserts both request types, only the deactivate is granted. The update stays pending for a later round.
- **State machine.**
  - ST_IDLE: when any request is pending and `ga_ocupado_in`=0, select the winner, latch its payload and index, advance the pointer to the winner, and go to ST_EMITIR.
  - ST_EMITIR, exactly 1 cycle:
    - Drive `arb_desativar_out` or `arb_atualizar_out`=1.
    - Drive the grant bit of the winner.
    - Hold the payload.
    - Go to ST_AGUARDAR.
  - ST_AGUARDAR: hold the payload. Go to ST_IDLE on the first cycle with `ga_ocupado_in`=0.
- **Selection.** Search indices pointer+1, pointer+2, … modulo `NUM_REQ`, wrapping from `NUM_REQ-1` to 0. The first pending index wins.
- **Payload.** The payload outputs keep their last value in ST_IDLE; they are not zeroed.
- **Requests while busy.** Requests that arrive during ST_EMITIR or ST_AGUARDAR wait; none are dropped.
- **Full manager.** `ga_buffers_cheios_in` does not block issue. The manager stalls updates internally until a slot frees. The flag only affects priority (see Configuration).
- **Reset mid-operation.** Synchronous reset in any state returns to the reset values on the next edge. A grant that has not yet been issued is lost, and the requester keeps requesting.

## Timing
- **Latency.** Request seen in ST_IDLE at edge N: command pulse and grant are high in cycle N+1 (ST_EMITIR).
- **Back-to-back.** The minimum spacing between commands is 3 cycles: EMITIR, AGUARDAR with manager busy ≥1 cycle, then IDLE.
- **Manager busy.** `ga_ocupado_in` must rise in the cycle after ST_EMITIR. If it is already 0 in ST_AGUARDAR, return to ST_IDLE immediately.
- **Pointer update.** The pointer updates only on the ST_IDLE→ST_EMITIR transition.

## Configuration
- Macro: `ARB_GA_PRIORIDADE_DESATIVAR_EN`.
- **Defined:** two-level arbitration.
  - The deactivate class is searched first, round-robin.
  - The update class is searched only when no deactivate is pending.
  - Both classes share one pointer.
  - While `ga_buffers_cheios_in`=1 and any deactivate is pending, updates are never selected.
- **Undefined:** single round-robin over all requesters. For each requester the request is `req_desativar_in`|`req_atualizar_in`, and the winner's type is deactivate if its deactivate bit is set, otherwise update.

## Test plan
- **Reset, then single request.** Requester 2 asserts update with addr=5 → in the next cycle `arb_atualizar_out`=1, `arb_grant_out`=0100, `arb_endereco_out`=5, `arb_indice_out`=2.
- **Round-robin.** All 4 requesters hold update, manager model busy for 2 cycles per command → grants in order 0,1,2,3,0. Each grant is ≥4 cycles apart.
- **Priority (macro defined).** Requesters 0,1 update and requester 3 deactivate, with `ga_buffers_cheios_in`=1 → requester 3 is served first. Without the macro, requester 0 is served first.
- **Busy gating.** `ga_ocupado_in` held at 1 for 10 cycles while a request is pending → no command pulse until the cycle after it drops.
- **Dual request.** Requester 1 asserts both types → the deactivate is issued and granted. The update is issued on the next round after requester 1 drops the deactivate.
- **Mid-op reset.** `rst_n`=0 during ST_AGUARDAR → all outputs are 0 and the state is ST_IDLE after the edge. The pending request is re-granted after release.

Source files
------------

// File: rtl/arbitro_gerenciador_ativos.sv
// Round-robin arbiter that owns the command port of gerenciador_ativos and issues one command at a time.
// Define ARB_GA_PRIORIDADE_DESATIVAR_EN to give deactivate requests precedence over updates.
module arbitro_gerenciador_ativos #(
  parameter int NUM_REQ         = 4,
  parameter int REQ_IDX_WIDTH   = $clog2(NUM_REQ),
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_desativar_in,
  input  logic [NUM_REQ-1:0]                 req_atualizar_in,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]      req_endereco_in,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]      req_anterior_in,
  input  logic [CUSTO_WIDTH*NUM_REQ-1:0]     req_menor_vizinho_in,
  input  logic [DISTANCIA_WIDTH*NUM_REQ-1:0] req_distancia_in,
  input  logic                               ga_ocupado_in,
  input  logic                               ga_buffers_cheios_in,
  output logic [NUM_REQ-1:0]                 arb_grant_out,
  output logic [REQ_IDX_WIDTH-1:0]           arb_indice_out,
  output logic                               arb_desativar_out,
  output logic                               arb_atualizar_out,
  output logic [ADDR_WIDTH-1:0]              arb_endereco_out,
  output logic [ADDR_WIDTH-1:0]              arb_anterior_out,
  output logic [CUSTO_WIDTH-1:0]             arb_menor_vizinho_out,
  output logic [DISTANCIA_WIDTH-1:0]         arb_distancia_out,
  output logic                               arb_ocupado_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMITIR   = 2'd1,
    ST_AGUARDAR = 2'd2
  } estado_t;

  estado_t                    estado_r, estado_s;
  logic [REQ_IDX_WIDTH-1:0]   ptr_r;
  logic [REQ_IDX_WIDTH:0]     busca_s;
  logic                       achou_s;
  logic [REQ_IDX_WIDTH-1:0]   vencedor_s;
  logic                       tipo_desat_s;
  logic                       inicia_s;
  logic [NUM_REQ-1:0]         grant_s;

  logic [NUM_REQ-1:0]         grant_r;
  logic [REQ_IDX_WIDTH-1:0]   indice_r;
  logic                       desativar_r;
  logic                       atualizar_r;
  logic [ADDR_WIDTH-1:0]      endereco_r;
  logic [ADDR_WIDTH-1:0]      anterior_r;
  logic [CUSTO_WIDTH-1:0]     menor_vizinho_r;
  logic [DISTANCIA_WIDTH-1:0] distancia_r;
  logic                       ocupado_r;

  // Deactivates already take precedence whenever any is pending, so the full flag cannot change the choice.
  logic unused_cheios_s;
  assign unused_cheios_s = ga_buffers_cheios_in;

  // Returns {found, index} of the first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  function automatic logic [REQ_IDX_WIDTH:0] rr_busca(input logic [NUM_REQ-1:0] pend,
                                                      input logic [REQ_IDX_WIDTH-1:0] ptr);
    logic                     achou;
    logic [REQ_IDX_WIDTH-1:0] idx;
    logic [REQ_IDX_WIDTH-1:0] cand;
    int                       pos;
    achou = 1'b0;
    idx   = {REQ_IDX_WIDTH{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos  = (int'(ptr) + k) % NUM_REQ;
      cand = REQ_IDX_WIDTH'(pos);
      if (!achou && pend[cand]) begin
        achou = 1'b1;
        idx   = cand;
      end else begin
        achou = achou;
      end
    end
    return {achou, idx};
  endfunction

  // Winner selection and command type for the current pointer.
  always_comb begin
    busca_s      = {(REQ_IDX_WIDTH+1){1'b0}};
    tipo_desat_s = 1'b0;
`ifdef ARB_GA_PRIORIDADE_DESATIVAR_EN
    if (|req_desativar_in) begin
      busca_s      = rr_busca(req_desativar_in, ptr_r);
      tipo_desat_s = 1'b1;
    end else begin
      busca_s      = rr_busca(req_atualizar_in, ptr_r);
      tipo_desat_s = 1'b0;
    end
`else
    busca_s      = rr_busca(req_desativar_in | req_atualizar_in, ptr_r);
    tipo_desat_s = req_desativar_in[busca_s[REQ_IDX_WIDTH-1:0]];
`endif
  end

  assign achou_s    = busca_s[REQ_IDX_WIDTH];
  assign vencedor_s = busca_s[REQ_IDX_WIDTH-1:0];
  assign grant_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << vencedor_s;

  // Next-state logic; inicia_s marks the single IDLE->EMITIR issue decision.
  always_comb begin
    estado_s = estado_r;
    inicia_s = 1'b0;
    case (estado_r)
      ST_IDLE: begin
        if (achou_s && !ga_ocupado_in) begin
          estado_s = ST_EMITIR;
          inicia_s = 1'b1;
        end else begin
          estado_s = ST_IDLE;
        end
      end
      ST_EMITIR: begin
        estado_s = ST_AGUARDAR;
      end
      ST_AGUARDAR: begin
        if (!ga_ocupado_in) begin
          estado_s = ST_IDLE;
        end else begin
          estado_s = ST_AGUARDAR;
        end
      end
      default: begin
        estado_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs; payload is only reloaded on issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_r        <= ST_IDLE;
      ptr_r           <= REQ_IDX_WIDTH'(NUM_REQ - 1);
      grant_r         <= {NUM_REQ{1'b0}};
      indice_r        <= {REQ_IDX_WIDTH{1'b0}};
      desativar_r     <= 1'b0;
      atualizar_r     <= 1'b0;
      endereco_r      <= {ADDR_WIDTH{1'b0}};
      anterior_r      <= {ADDR_WIDTH{1'b0}};
      menor_vizinho_r <= {CUSTO_WIDTH{1'b0}};
      distancia_r     <= {DISTANCIA_WIDTH{1'b0}};
      ocupado_r       <= 1'b0;
    end else begin
      estado_r  <= estado_s;
      ocupado_r <= (estado_s != ST_IDLE);
      if (inicia_s) begin
        ptr_r           <= vencedor_s;
        indice_r        <= vencedor_s;
        grant_r         <= grant_s;
        desativar_r     <= tipo_desat_s;
        atualizar_r     <= !tipo_desat_s;
        endereco_r      <= req_endereco_in[ADDR_WIDTH*vencedor_s +: ADDR_WIDTH];
        anterior_r      <= req_anterior_in[ADDR_WIDTH*vencedor_s +: ADDR_WIDTH];
        menor_vizinho_r <= req_menor_vizinho_in[CUSTO_WIDTH*vencedor_s +: CUSTO_WIDTH];
        distancia_r     <= req_distancia_in[DISTANCIA_WIDTH*vencedor_s +: DISTANCIA_WIDTH];
      end else begin
        grant_r     <= {NUM_REQ{1'b0}};
        desativar_r <= 1'b0;
        atualizar_r <= 1'b0;
      end
    end
  end

  assign arb_grant_out         = grant_r;
  assign arb_indice_out        = indice_r;
  assign arb_desativar_out     = desativar_r;
  assign arb_atualizar_out     = atualizar_r;
  assign arb_endereco_out      = endereco_r;
  assign arb_anterior_out      = anterior_r;
  assign arb_menor_vizinho_out = menor_vizinho_r;
  assign arb_distancia_out     = distancia_r;
  assign arb_ocupado_o         = ocupado_r;

endmodule

// File: tb/tb_arbitro_gerenciador_ativos.sv
// Self-checking bench for arbitro_gerenciador_ativos: directed table, corner sequences, random vs reference model.
module tb_arbitro_gerenciador_ativos;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_d, req_a;
  logic [AW*N-1:0] req_end, req_ant;
  logic [CW*N-1:0] req_men;
  logic [DW*N-1:0] req_dist;
  logic          ga_ocup, ga_cheios;
  logic [N-1:0]  arb_grant;
  logic [1:0]    arb_idx;
  logic          arb_des, arb_atu;
  logic [AW-1:0] arb_end, arb_ant;
  logic [CW-1:0] arb_men;
  logic [DW-1:0] arb_dist;
  logic          arb_ocup;

  logic [AW-1:0] p_end[N], p_ant[N];
  logic [CW-1:0] p_men[N];
  logic [DW-1:0] p_dist[N];

  int vec_cnt  = 0;
  int fail_cnt = 0;

  arbitro_gerenciador_ativos dut (
    .clk(clk), .rst_n(rst_n),
    .req_desativar_in(req_d), .req_atualizar_in(req_a),
    .req_endereco_in(req_end), .req_anterior_in(req_ant),
    .req_menor_vizinho_in(req_men), .req_distancia_in(req_dist),
    .ga_ocupado_in(ga_ocup), .ga_buffers_cheios_in(ga_cheios),
    .arb_grant_out(arb_grant), .arb_indice_out(arb_idx),
    .arb_desativar_out(arb_des), .arb_atualizar_out(arb_atu),
    .arb_endereco_out(arb_end), .arb_anterior_out(arb_ant),
    .arb_menor_vizinho_out(arb_men), .arb_distancia_out(arb_dist),
    .arb_ocupado_o(arb_ocup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_end[AW*i +: AW]  = p_end[i];
      req_ant[AW*i +: AW]  = p_ant[i];
      req_men[CW*i +: CW]  = p_men[i];
      req_dist[DW*i +: DW] = p_dist[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         rst_n;
    logic [N-1:0] d, a;
    logic         ocup;
    logic [N-1:0] e_grant;
    logic [1:0]   e_idx;
    logic         e_des, e_atu;
    logic [AW-1:0] e_end;
    logic         e_ocup;
  } vec_t;

  vec_t tab[24];

  function automatic vec_t mk(logic r, logic [3:0] d, logic [3:0] a, logic o, logic [3:0] g,
                              logic [1:0] ix, logic de, logic at, logic [4:0] en, logic eo);
    vec_t v;
    v.rst_n = r; v.d = d; v.a = a; v.ocup = o; v.e_grant = g; v.e_idx = ix;
    v.e_des = de; v.e_atu = at; v.e_end = en; v.e_ocup = eo;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int            m_st;   // 0 idle, 1 command cycle, 2 waiting for manager
  int            m_ptr;
  logic [N-1:0]  m_grant;
  int            m_idx;
  logic          m_des, m_atu;
  logic [AW-1:0] m_end, m_ant;
  logic [CW-1:0] m_men;
  logic [DW-1:0] m_dist;

  function automatic int first_rr(logic [N-1:0] mask, int ptr);
    for (int k = 1; k <= N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_advance();
    int  w;
    bit  wdes;
    m_grant = '0; m_des = 1'b0; m_atu = 1'b0;
    if (!rst_n) begin
      m_st = 0; m_ptr = N - 1; m_idx = 0;
      m_end = '0; m_ant = '0; m_men = '0; m_dist = '0;
      return;
    end
    if (m_st == 0) begin
`ifdef ARB_GA_PRIORIDADE_DESATIVAR_EN
      if (req_d != 0) begin w = first_rr(req_d, m_ptr); wdes = 1'b1; end
      else begin w = first_rr(req_a, m_ptr); wdes = 1'b0; end
`else
      w = first_rr(req_d | req_a, m_ptr);
      wdes = (w >= 0) ? req_d[w] : 1'b0;
`endif
      if (w >= 0 && !ga_ocup) begin
        m_st = 1; m_ptr = w; m_idx = w;
        m_grant[w] = 1'b1; m_des = wdes; m_atu = !wdes;
        m_end = p_end[w]; m_ant = p_ant[w]; m_men = p_men[w]; m_dist = p_dist[w];
      end
    end else if (m_st == 1) begin
      m_st = 2;
    end else begin
      if (!ga_ocup) m_st = 0;
    end
  endtask

  int grants_seen;
  int last_cyc, cyc;
  int busy;

  initial begin
    rst_n = 1'b0; req_d = '0; req_a = '0; ga_ocup = 1'b0; ga_cheios = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_end[i]  = (i == 2) ? 5'd5 : 5'(10 + i);
      p_ant[i]  = 5'(20 + i);
      p_men[i]  = 4'(i + 1);
      p_dist[i] = 5'(3 * i);
    end

    tab[0]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0);
    tab[1]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0);
    tab[2]  = mk(1'b1, 4'b0000, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b1, 5'd5,  1'b1);
    tab[3]  = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 5'd5,  1'b1);
    tab[4]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 5'd5,  1'b0);
    for (int k = 5; k < 15; k++)
      tab[k] = mk(1'b1, 4'b0000, 4'b0001, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 5'd5, 1'b0);
    tab[15] = mk(1'b1, 4'b0000, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1, 5'd10, 1'b1);
    tab[16] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd10, 1'b1);
    tab[17] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd10, 1'b0);
    tab[18] = mk(1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 5'd11, 1'b1);
    tab[19] = mk(1'b1, 4'b0000, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 5'd11, 1'b1);
    tab[20] = mk(1'b1, 4'b0000, 4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 5'd11, 1'b0);
    tab[21] = mk(1'b1, 4'b0000, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 5'd11, 1'b1);
    tab[22] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 5'd11, 1'b1);
    tab[23] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 5'd11, 1'b0);

    // reset, single request, busy gating and dual request
    for (int k = 0; k < 24; k++) begin
      rst_n = tab[k].rst_n; req_d = tab[k].d; req_a = tab[k].a; ga_ocup = tab[k].ocup;
      tick();
      chk($sformatf("tab%0d_grant", k), 32'(arb_grant), 32'(tab[k].e_grant));
      chk($sformatf("tab%0d_idx",   k), 32'(arb_idx),   32'(tab[k].e_idx));
      chk($sformatf("tab%0d_des",   k), 32'(arb_des),   32'(tab[k].e_des));
      chk($sformatf("tab%0d_atu",   k), 32'(arb_atu),   32'(tab[k].e_atu));
      chk($sformatf("tab%0d_end",   k), 32'(arb_end),   32'(tab[k].e_end));
      chk($sformatf("tab%0d_ocup",  k), 32'(arb_ocup),  32'(tab[k].e_ocup));
    end

    // priority with a full manager
    rst_n = 1'b0; req_d = '0; req_a = '0; tick();
    rst_n = 1'b1; ga_cheios = 1'b1; req_d = 4'b1000; req_a = 4'b0011; tick();
`ifdef ARB_GA_PRIORIDADE_DESATIVAR_EN
    chk("prio_grant", 32'(arb_grant), 32'(4'b1000));
    chk("prio_des",   32'(arb_des),   32'd1);
`else
    chk("prio_grant", 32'(arb_grant), 32'(4'b0001));
    chk("prio_atu",   32'(arb_atu),   32'd1);
`endif
    req_d = '0; req_a = '0; ga_cheios = 1'b0; tick(); tick();

    // round-robin with all requesters holding updates, manager busy 2 cycles per command
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req_a = 4'b1111; busy = 0; grants_seen = 0; last_cyc = -100;
    for (cyc = 0; cyc < 80 && grants_seen < 5; cyc++) begin
      tick();
      if (arb_atu) begin
        chk($sformatf("rr_idx%0d", grants_seen), 32'(arb_idx), 32'(grants_seen % N));
        chk($sformatf("rr_gnt%0d", grants_seen), 32'(arb_grant), 32'(4'b0001 << (grants_seen % N)));
        if (grants_seen > 0)
          chk($sformatf("rr_gap%0d", grants_seen), 32'(cyc - last_cyc >= 4), 32'd1);
        last_cyc = cyc; grants_seen++; busy = 2;
      end
      ga_ocup = (busy > 0);
      if (busy > 0) busy--;
    end
    chk("rr_count", 32'(grants_seen), 32'd5);
    req_a = '0; ga_ocup = 1'b0; tick(); tick(); tick();

    // reset while waiting on the manager
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req_a = 4'b1000; tick();
    chk("mr_first_grant", 32'(arb_grant), 32'(4'b1000));
    ga_ocup = 1'b1; tick();
    chk("mr_wait_ocup", 32'(arb_ocup), 32'd1);
    rst_n = 1'b0; tick();
    chk("mr_rst_outs", {arb_grant, arb_idx, arb_des, arb_atu, arb_ocup, 24'd0}, 32'd0);
    chk("mr_rst_payload", {arb_end, arb_ant, arb_men, arb_dist, 13'd0}, 32'd0);
    rst_n = 1'b1; ga_ocup = 1'b0; tick();
    chk("mr_regrant", 32'(arb_grant), 32'(4'b1000));
    chk("mr_regrant_atu", 32'(arb_atu), 32'd1);
    req_a = '0; tick(); tick();

    // randomized traffic against the reference model
    rst_n = 1'b0; req_d = '0; req_a = '0; ga_ocup = 1'b0; busy = 0;
    model_advance();
    tick();
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_grant", 32'(arb_grant), 32'(m_grant));
      chk("rnd_idx",   32'(arb_idx),   32'(m_idx));
      chk("rnd_cmd",   {30'd0, arb_des, arb_atu}, {30'd0, m_des, m_atu});
      chk("rnd_pay",   {arb_end, arb_ant, arb_men, arb_dist, 13'd0}, {m_end, m_ant, m_men, m_dist, 13'd0});
      chk("rnd_ocup",  32'(arb_ocup),  32'(m_st != 0));
      for (int i = 0; i < N; i++) begin
        if (m_grant[i]) begin
          if (m_des) req_d[i] = 1'b0;
          else       req_a[i] = 1'b0;
        end
      end
      if (m_des || m_atu) busy = $urandom_range(0, 3);
      ga_ocup = (busy > 0) || ($urandom_range(0, 9) == 0);
      if (busy > 0) busy--;
      rst_n = ($urandom_range(0, 199) != 0);
      ga_cheios = $urandom_range(0, 1) == 1;
      for (int i = 0; i < N; i++) begin
        if (!req_d[i] && !req_a[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0:       req_d[i] = 1'b1;
            1:       req_a[i] = 1'b1;
            default: begin req_d[i] = 1'b1; req_a[i] = 1'b1; end
          endcase
          p_end[i]  = 5'($urandom);
          p_ant[i]  = 5'($urandom);
          p_men[i]  = 4'($urandom);
          p_dist[i] = 5'($urandom);
        end
      end
      model_advance();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
